// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding, default
// parameter values and the clock-to-tick divide ratio helper.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int DEFAULT_CLK_HZ    = 100_000_000;
  localparam int DEFAULT_TICK_HZ   = 10;
  localparam int DEFAULT_MAX_COUNT = 9999;
  localparam int DEFAULT_CNT_W     = 14;

  // Number of clk cycles per decrement; callers keep this >= 2.
  function automatic int div_ratio(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Tick enable generator: a divider that counts 0..DIV-1 while enabled and
// emits a one-cycle tick on the last count. Held at 0 whenever disabled, so
// every enable starts a fresh full period.
module tick_gen
  import countdown_timer_pkg::*;
#(
  parameter int CLK_HZ  = DEFAULT_CLK_HZ,
  parameter int TICK_HZ = DEFAULT_TICK_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int DIV = div_ratio(CLK_HZ, TICK_HZ);
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] r_div;
  logic             w_wrap;

  assign w_wrap = (r_div == DIV_LAST);

  // Divider: clear when disabled or on the last count, otherwise advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (!en || w_wrap) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_ONE;
    end
  end

  assign tick = en & w_wrap;

endmodule

// File: rtl/countdown_timer.sv
// Preset down-counter. A loaded value is decremented once per tick while
// running; reaching 0 raises a one-cycle done pulse and parks in EXPIRED.
// All outputs come from registers (state, count, done).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int CLK_HZ    = DEFAULT_CLK_HZ,
  parameter int TICK_HZ   = DEFAULT_TICK_HZ,
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  output logic [CNT_W-1:0] cnt,
  output logic             running,
  output logic             expired,
  output logic             done
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_load_sat;
  logic             r_done;
  logic             w_done_next;
  logic             w_tick;
  logic             w_tick_en;

  // Oversized presets clamp to the largest displayable count.
  assign w_load_sat = (load_val > MAX_V) ? MAX_V : load_val;
  assign w_tick_en  = (r_state == ST_RUN);

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (w_tick_en),
    .tick(w_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: load beats start, stop beats both start and tick.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!load && start && !stop && (r_cnt != '0)) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_next = ST_PAUSE;
        end else if (w_tick && (r_cnt == ONE_V)) begin
          w_state_next = ST_EXPIRED;
        end
      end
      ST_PAUSE: begin
        if (load) begin
          w_state_next = ST_IDLE;
        end else if (start && !stop) begin
          w_state_next = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        if (load) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Count datapath: decrement on an unstopped tick in RUN, preset elsewhere.
  always_comb begin
    w_cnt_next  = r_cnt;
    w_done_next = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!stop && w_tick && (r_cnt != '0)) begin
          w_cnt_next  = r_cnt - ONE_V;
          w_done_next = (r_cnt == ONE_V);
        end
      end
      default: begin
        if (load) begin
          w_cnt_next = w_load_sat;
        end
      end
    endcase
  end

  // Count and done registers; done is high only on the cycle cnt reaches 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_done <= w_done_next;
    end
  end

  // Output decode of the state register.
  always_comb begin
    running = (r_state == ST_RUN);
    expired = (r_state == ST_EXPIRED);
  end

  assign cnt  = r_cnt;
  assign done = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with DIV=10: directed scenarios with literal
// expectations, then random pulses, all checked every cycle against a
// behavioural model (elapsed-cycle counting, plain integer arithmetic).
module tb_countdown_timer;

  localparam int DIV  = 10;
  localparam int MAXC = 9999;

  logic        clk;
  logic        rst;
  logic        load;
  logic        start;
  logic        stop;
  logic [13:0] load_val;
  logic [13:0] cnt;
  logic        running;
  logic        expired;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Model state: count, activity flags, cycles since last (re)start/decrement.
  int m_cnt     = 0;
  int m_elapsed = 0;
  bit m_run     = 0;
  bit m_pause   = 0;
  bit m_exp     = 0;
  bit m_done    = 0;

  countdown_timer #(
    .CLK_HZ   (100),
    .TICK_HZ  (10),
    .MAX_COUNT(MAXC),
    .CNT_W    (14)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .start   (start),
    .stop    (stop),
    .cnt     (cnt),
    .running (running),
    .expired (expired),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference, updated on each edge from the sampled inputs.
  always @(posedge clk or posedge rst) begin : model
    int c;
    int e;
    int sat;
    bit r;
    bit p;
    bit x;
    bit d;
    if (rst) begin
      m_cnt <= 0; m_elapsed <= 0; m_run <= 0; m_pause <= 0; m_exp <= 0; m_done <= 0;
    end else begin
      c = m_cnt; e = m_elapsed; r = m_run; p = m_pause; x = m_exp; d = 0;
      sat = (int'(load_val) > MAXC) ? MAXC : int'(load_val);
      if (r) begin
        if (stop) begin
          r = 0; p = 1;
        end else begin
          e = e + 1;
          if (e == DIV) begin
            e = 0;
            c = c - 1;
            if (c == 0) begin r = 0; x = 1; d = 1; end
          end
        end
      end else if (p) begin
        if (load) begin c = sat; p = 0; end
        else if (start && !stop) begin r = 1; p = 0; e = 0; end
      end else if (x) begin
        if (load) begin c = sat; x = 0; end
      end else begin
        if (load) c = sat;
        else if (start && !stop && c != 0) begin r = 1; e = 0; end
      end
      m_cnt <= c; m_elapsed <= e; m_run <= r; m_pause <= p; m_exp <= x; m_done <= d;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cnt", int'(cnt), m_cnt);
      chk("running", int'(running), int'(m_run));
      chk("expired", int'(expired), int'(m_exp));
      chk("done", int'(done), int'(m_done));
    end
  end

  task automatic pulse(input logic l, input logic s, input logic p, input int v);
    load = l; start = s; stop = p; load_val = 14'(v);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; load_val = '0;
    wait_cyc(2);
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_expired", int'(expired), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;
    wait_cyc(1);

    // 1: load 5, start, count down at 10-cycle spacing
    pulse(1, 0, 0, 5);
    pulse(0, 1, 0, 0);
    chk("t1_running", int'(running), 1);
    for (int k = 1; k <= 5; k++) begin
      wait_cyc(9);
      chk("t1_pre_dec", int'(cnt), 6 - k);
      wait_cyc(1);
      chk("t1_cnt", int'(cnt), 5 - k);
    end
    chk("t1_done", int'(done), 1);
    chk("t1_expired", int'(expired), 1);
    chk("t1_running_off", int'(running), 0);
    wait_cyc(1);
    chk("t1_done_once", int'(done), 0);

    // 2: pause at cycle 15, resume after 40 cycles
    pulse(1, 0, 0, 3);
    pulse(0, 1, 0, 0);
    wait_cyc(14);
    pulse(0, 0, 1, 0);
    chk("t2_paused_cnt", int'(cnt), 2);
    chk("t2_paused_run", int'(running), 0);
    wait_cyc(40);
    chk("t2_hold_cnt", int'(cnt), 2);
    pulse(0, 1, 0, 0);
    wait_cyc(9);
    chk("t2_pre", int'(cnt), 2);
    wait_cyc(1);
    chk("t2_dec", int'(cnt), 1);
    wait_cyc(10);
    chk("t2_zero", int'(cnt), 0);
    chk("t2_done", int'(done), 1);

    // 3: saturation and start with zero count
    pulse(1, 0, 0, 12000);
    chk("t3_sat", int'(cnt), 9999);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    chk("t3_zero_start", int'(running), 0);
    chk("t3_zero_cnt", int'(cnt), 0);

    // 4: load ignored in RUN; start ignored in EXPIRED
    pulse(1, 0, 0, 7);
    pulse(0, 1, 0, 0);
    wait_cyc(3);
    pulse(1, 0, 0, 2);
    chk("t4_load_ign", int'(cnt), 7);
    chk("t4_still_run", int'(running), 1);
    wait_cyc(66);
    chk("t4_expired", int'(expired), 1);
    chk("t4_exp_cnt", int'(cnt), 0);
    pulse(0, 1, 0, 0);
    chk("t4_start_ign", int'(expired), 1);
    pulse(1, 0, 0, 4);
    chk("t4_reload", int'(cnt), 4);
    chk("t4_idle", int'(expired) + int'(running), 0);

    // 5: stop on the final tick cycle suppresses the decrement and done
    pulse(1, 0, 0, 1);
    pulse(0, 1, 0, 0);
    wait_cyc(9);
    pulse(0, 0, 1, 0);
    chk("t5_cnt", int'(cnt), 1);
    chk("t5_done", int'(done), 0);
    chk("t5_paused", int'(running), 0);
    pulse(0, 1, 0, 0);
    wait_cyc(10);
    chk("t5_resume_done", int'(done), 1);

    // 6: asynchronous reset mid-run
    pulse(1, 0, 0, 9);
    pulse(0, 1, 0, 0);
    wait_cyc(30);
    chk("t6_cnt6", int'(cnt), 6);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_cnt", int'(cnt), 0);
    chk("t6_async_run", int'(running), 0);
    chk("t6_async_exp", int'(expired), 0);
    wait_cyc(1);
    rst = 1'b0;
    pulse(0, 1, 0, 0);
    chk("t6_start_ign", int'(running), 0);

    // Random pulses checked by the per-cycle model comparison
    for (int i = 0; i < 4000; i++) begin
      load     = ($urandom_range(0, 29) == 0);
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 59) == 0);
      load_val = ($urandom_range(0, 9) == 0) ? 14'($urandom_range(9990, 16383))
                                             : 14'($urandom_range(0, 6));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #1 chk("rand_async_cnt", int'(cnt), 0);
      end
      @(negedge clk);
      rst = 1'b0;
    end
    load = 1'b0; start = 1'b0; stop = 1'b0;
    wait_cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
